vote_kofn: RTL and testbench

Registered, parametrised K-of-N majority voter for redundant channels, the next generation of the three-input 2-of-3 voter. It votes bitwise across N channels of W bits each and filters the result for persistence before it reaches the output. It also tracks per-channel disagreement and flags channels that disagree persistently. It sits between replicated producers (TMR logic, redundant sensors) and a single consumer.

---
 rtl/vote_kofn.sv | 127 ++++++++++++
 tb/tb_vote_kofn.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vote_kofn.sv
// K-of-N bitwise majority voter with a persistence filter on the output
// and per-channel persistent-disagreement flags.
// Pipeline: stage 1 registers the channel inputs; stage 2 votes on the
// registered sample, filters the vote and updates the fault tracking.
module vote_kofn #(
  parameter int N    = 3,
  parameter int K    = 2,
  parameter int W    = 1,
  parameter int HOLD = 1,
  parameter int FLT  = 4
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           EN,
  input  logic [N*W-1:0] D,
  output logic [W-1:0]   Y,
  output logic           VALID,
  output logic           MISMATCH,
  output logic [N-1:0]   FLT_FLAG
);

  // popcount must hold N; counters must hold their saturation values
  localparam int PW = $clog2(N + 1);
  localparam int CW = $clog2(HOLD + 1);
  localparam int FW = $clog2(FLT + 1);

  // Reject unsupported parameter combinations at elaboration time
  if (N < 2 || N > 16 || K < 1 || K > N || W < 1 || W > 32 ||
      HOLD < 1 || FLT < 1) begin : g_param_check
    $fatal(1, "vote_kofn: parameter out of range (N=%0d K=%0d W=%0d HOLD=%0d FLT=%0d)",
           N, K, W, HOLD, FLT);
  end

  // Handshake: EN is a one-way strobe with no back-pressure; a sample is
  // taken on every rising edge where EN=1 and the block is never busy.

  logic [N*W-1:0] d_r;
  logic           v1;
  logic [W-1:0]   vote;
  logic [PW-1:0]  ones [W];
  logic [N-1:0]   dis;
  logic [W-1:0]   cand;
  logic [CW-1:0]  cnt;
  logic [CW-1:0]  next_cnt;
  logic [FW-1:0]  fc      [N];
  logic [FW-1:0]  fc_next [N];

  // Stage 1: capture the channels when strobed; v1 marks a fresh sample
  always_ff @(posedge CLK) begin
    if (RST) begin
      d_r <= '0;
      v1  <= 1'b0;
    end else begin
      v1 <= EN;
      if (EN) d_r <= D;
    end
  end

  // Bitwise vote: count the channels holding a 1 in each bit position
  always_comb begin
    for (int b = 0; b < W; b++) begin
      ones[b] = '0;
      for (int i = 0; i < N; i++) begin
        ones[b] = ones[b] + PW'(d_r[i*W + b]);
      end
      vote[b] = (ones[b] >= PW'(K));
    end
  end

  // A channel disagrees when any of its bits differs from the vote
  always_comb begin
    for (int i = 0; i < N; i++) begin
      dis[i] = (d_r[i*W +: W] != vote);
    end
  end

  // Persistence run length: a changed vote starts a new run at 1
  always_comb begin
    next_cnt = CW'(1);
    if (vote == cand) begin
      next_cnt = (cnt == CW'(HOLD)) ? CW'(HOLD) : cnt + CW'(1);
    end
  end

  // Per-channel disagreement run length, saturating at FLT
  always_comb begin
    for (int i = 0; i < N; i++) begin
      fc_next[i] = '0;
      if (dis[i]) begin
        fc_next[i] = (fc[i] == FW'(FLT)) ? FW'(FLT) : fc[i] + FW'(1);
      end
    end
  end

  // Stage 2 filter and output: Y only moves once a vote has persisted
  always_ff @(posedge CLK) begin
    if (RST) begin
      cand     <= '0;
      cnt      <= '0;
      Y        <= '0;
      VALID    <= 1'b0;
      MISMATCH <= 1'b0;
    end else if (v1) begin
      cand     <= vote;
      cnt      <= next_cnt;
      MISMATCH <= |dis;
      if (next_cnt == CW'(HOLD)) begin
        Y     <= vote;
        VALID <= 1'b1;
      end
    end
  end

  // Stage 2 fault tracking: flags are sticky until reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < N; i++) fc[i] <= '0;
      FLT_FLAG <= '0;
    end else if (v1) begin
      for (int i = 0; i < N; i++) begin
        fc[i] <= fc_next[i];
        if (fc_next[i] == FW'(FLT)) FLT_FLAG[i] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vote_kofn.sv
// Bench for vote_kofn: two instances (3x1-bit 2-of-3 with HOLD=1, and
// 5x4-bit 3-of-5 with HOLD=3) checked every cycle against a history-based
// reference model, plus directed scenarios and randomized traffic.
module tb_vote_kofn;

  logic        clk;
  logic        rst_a, en_a;
  logic [2:0]  d_a;
  logic [0:0]  y_a;
  logic        valid_a, mm_a;
  logic [2:0]  flag_a;

  logic        rst_b, en_b;
  logic [19:0] d_b;
  logic [3:0]  y_b;
  logic        valid_b, mm_b;
  logic [4:0]  flag_b;

  int n_tests = 0;
  int n_fail  = 0;

  // Clock and DUTs
  initial clk = 1'b0;
  always #5 clk = ~clk;

  vote_kofn #(.N(3), .K(2), .W(1), .HOLD(1), .FLT(4)) dut_a (
    .CLK(clk), .RST(rst_a), .EN(en_a), .D(d_a),
    .Y(y_a), .VALID(valid_a), .MISMATCH(mm_a), .FLT_FLAG(flag_a)
  );

  vote_kofn #(.N(5), .K(3), .W(4), .HOLD(3), .FLT(2)) dut_b (
    .CLK(clk), .RST(rst_b), .EN(en_b), .D(d_b),
    .Y(y_b), .VALID(valid_b), .MISMATCH(mm_b), .FLT_FLAG(flag_b)
  );

  // Reference model: per-instance parameters and sample histories
  int n_p    [2] = '{3, 5};
  int k_p    [2] = '{2, 3};
  int w_p    [2] = '{1, 4};
  int hold_p [2] = '{1, 3};
  int flt_p  [2] = '{4, 2};

  logic        pend_v [2];
  logic [19:0] pend_d [2];
  logic [3:0]  vq_0 [$];
  logic [3:0]  vq_1 [$];
  logic [4:0]  dq_0 [$];
  logic [4:0]  dq_1 [$];
  logic [3:0]  exp_y     [2];
  logic        exp_valid [2];
  logic        exp_mm    [2];
  logic [4:0]  exp_flag  [2];

  task automatic model_clear(input int inst);
    pend_v[inst]    = 1'b0;
    pend_d[inst]    = '0;
    exp_y[inst]     = '0;
    exp_valid[inst] = 1'b0;
    exp_mm[inst]    = 1'b0;
    exp_flag[inst]  = '0;
    if (inst == 0) begin
      vq_0.delete(); dq_0.delete();
    end else begin
      vq_1.delete(); dq_1.delete();
    end
  endtask

  // Process one sample: vote by counting, then read run lengths off the history
  task automatic model_sample(input int inst, input logic [19:0] d);
    logic [3:0] v;
    logic [4:0] dis;
    logic [3:0] vq [$];
    logic [4:0] dq [$];
    int ones;
    int run;
    v   = '0;
    dis = '0;
    for (int b = 0; b < w_p[inst]; b++) begin
      ones = 0;
      for (int c = 0; c < n_p[inst]; c++) ones += int'(d[c*w_p[inst] + b]);
      v[b] = (ones >= k_p[inst]);
    end
    for (int c = 0; c < n_p[inst]; c++)
      for (int b = 0; b < w_p[inst]; b++)
        if (d[c*w_p[inst] + b] != v[b]) dis[c] = 1'b1;
    if (inst == 0) begin
      vq_0.push_back(v); dq_0.push_back(dis); vq = vq_0; dq = dq_0;
    end else begin
      vq_1.push_back(v); dq_1.push_back(dis); vq = vq_1; dq = dq_1;
    end
    run = 0;
    for (int j = vq.size() - 1; j >= 0 && vq[j] == v; j--) run++;
    if (run >= hold_p[inst]) begin
      exp_y[inst]     = v;
      exp_valid[inst] = 1'b1;
    end
    exp_mm[inst] = |dis;
    for (int c = 0; c < n_p[inst]; c++) begin
      run = 0;
      for (int j = dq.size() - 1; j >= 0 && dq[j][c]; j--) run++;
      if (run >= flt_p[inst]) exp_flag[inst][c] = 1'b1;
    end
  endtask

  // One rising edge as seen by the model: sample in flight moves to stage 2
  task automatic model_edge(input int inst, input logic rst, input logic en,
                            input logic [19:0] d);
    if (rst) begin
      model_clear(inst);
    end else begin
      if (pend_v[inst]) model_sample(inst, pend_d[inst]);
      pend_v[inst] = en;
      if (en) pend_d[inst] = d;
    end
  endtask

  // Checking task
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    check("a_y",     32'(y_a),     32'(exp_y[0]));
    check("a_valid", 32'(valid_a), 32'(exp_valid[0]));
    check("a_mm",    32'(mm_a),    32'(exp_mm[0]));
    check("a_flag",  32'(flag_a),  32'(exp_flag[0]));
    check("b_y",     32'(y_b),     32'(exp_y[1]));
    check("b_valid", 32'(valid_b), 32'(exp_valid[1]));
    check("b_mm",    32'(mm_b),    32'(exp_mm[1]));
    check("b_flag",  32'(flag_b),  32'(exp_flag[1]));
  endtask

  // Driver: inputs are already set; advance one edge and check at the falling edge
  task automatic cycle();
    @(posedge clk);
    model_edge(0, rst_a, en_a, {17'b0, d_a});
    model_edge(1, rst_b, en_b, d_b);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n);
    en_a = 1'b0; en_b = 1'b0;
    repeat (n) cycle();
  endtask

  logic [3:0] base;

  initial begin
    model_clear(0);
    model_clear(1);

    // Reset held with all-ones data and EN high
    rst_a = 1'b1; rst_b = 1'b1; en_a = 1'b1; en_b = 1'b1;
    d_a = 3'b111; d_b = 20'hFFFFF;
    repeat (2) begin
      cycle();
      check("rst_a_y", 32'(y_a), 32'd0);
      check("rst_b_flag", 32'(flag_b), 32'd0);
    end
    rst_a = 1'b0; rst_b = 1'b0;
    idle(1);
    check("post_rst_a_valid", 32'(valid_a), 32'd0);
    check("post_rst_b_y", 32'(y_b), 32'd0);

    // 2-of-3 vote, HOLD=1
    en_a = 1'b1; d_a = 3'b011; cycle();
    d_a = 3'b111; cycle();
    check("vote23_y", 32'(y_a), 32'd1);
    check("vote23_valid", 32'(valid_a), 32'd1);
    check("vote23_mm", 32'(mm_a), 32'd1);
    idle(1);
    check("vote23_agree_mm", 32'(mm_a), 32'd0);
    check("vote23_agree_y", 32'(y_a), 32'd1);

    // Fault flag: 3 disagreements, 1 agreement, 4 disagreements on channel 0
    en_a = 1'b1;
    for (int s = 0; s < 8; s++) begin
      d_a = (s == 3) ? 3'b111 : 3'b110;
      cycle();
    end
    check("flt_before", 32'(flag_a), 32'd0);
    idle(1);
    check("flt_set", 32'(flag_a), 32'b001);
    en_a = 1'b1; d_a = 3'b111; repeat (2) cycle();
    idle(1);
    check("flt_sticky", 32'(flag_a), 32'b001);

    // Bitwise 3-of-5 over 4 bits, HOLD=3
    en_b = 1'b1; d_b = 20'hF5AAA; repeat (3) cycle();
    idle(1);
    check("bit_vote_y", 32'(y_b), 32'hA);
    check("bit_vote_mm", 32'(mm_b), 32'd1);
    en_b = 1'b1; d_b = 20'h33333; repeat (3) cycle();
    idle(1);
    check("bit_agree_y", 32'(y_b), 32'h3);
    check("bit_agree_mm", 32'(mm_b), 32'd0);

    // Persistence: votes F,0,F,F,F -> glitches filtered
    en_b = 1'b1;
    for (int s = 0; s < 5; s++) begin
      d_b = (s == 1) ? 20'h00000 : 20'hFFFFF;
      cycle();
    end
    check("persist_hold", 32'(y_b), 32'h3);
    idle(1);
    check("persist_update", 32'(y_b), 32'hF);

    // EN gaps do not break a run
    for (int s = 0; s < 3; s++) begin
      en_b = 1'b1; d_b = 20'h00000; cycle();
      if (s < 2) idle(5);
    end
    check("gap_before", 32'(y_b), 32'hF);
    idle(1);
    check("gap_update", 32'(y_b), 32'h0);

    // Reset mid-run restarts the filter
    en_b = 1'b1; d_b = 20'hAAAAA; cycle();
    en_b = 1'b0; cycle();
    rst_b = 1'b1; cycle();
    rst_b = 1'b0;
    check("midrst_valid", 32'(valid_b), 32'd0);
    en_b = 1'b1; repeat (2) cycle();
    idle(1);
    check("midrst_y_hold", 32'(y_b), 32'h0);
    check("midrst_valid_hold", 32'(valid_b), 32'd0);
    en_b = 1'b1; cycle();
    idle(1);
    check("midrst_y", 32'(y_b), 32'hA);
    check("midrst_valid_set", 32'(valid_b), 32'd1);

    // Randomized traffic on both instances
    for (int t = 0; t < 3000; t++) begin
      rst_a = ($urandom_range(0, 99) < 2);
      rst_b = ($urandom_range(0, 99) < 2);
      en_a  = ($urandom_range(0, 9) < 7);
      en_b  = ($urandom_range(0, 9) < 7);
      d_a   = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0:       base = 4'h0;
        1:       base = 4'hF;
        2:       base = 4'hA;
        default: base = 4'h3;
      endcase
      for (int c = 0; c < 5; c++)
        d_b[c*4 +: 4] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : base;
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
